uart_host_seq: RTL and testbench
================================

// Module: uart_host_seq
// PURPOSE
//  Bus master that owns the 16550-style UART register port. After reset it programs the UART:
//  divisor latch, 8N1 line control, FIFO control, interrupts off. It then arbitrates round-robin
//  between a byte-stream TX requester and RX polling, using LS polls to pace TR writes and RB reads.
//  Sits between the UART core and the SoC debug/loader logic.
// PARAMETERS
//  CLK_DIV      8'd3   divisor written to DL1 (clk/(16*baud)); DL2 always 8'h00
//  FIFO_TRIG    2'b00  RX FIFO trigger level, written to FC[7:6]
//  POLL_GAP     8      idle cycles between LS polls when nothing moved (>=1)
//  ACK_TIMEOUT  64     cycles without reg_ack before a bus transaction is aborted (>=2)
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous active-low reset
//  reg_req    out  1  UART register access request
//  reg_we     out  1  1=write, 0=read
//  reg_addr   out  3  UART register address (RB/TR=0, IE/DL2=1, FC=2, LC=3, LS=5, DL1=0)
//  reg_wdata  out  8  write data
//  reg_rdata  in   8  read data, valid in the reg_ack cycle
//  reg_ack    in   1  one-cycle transaction acknowledge
//  tx_valid   in   1  byte available to transmit
//  tx_data    in   8  byte to transmit
//  tx_ready   out  1  one-cycle pulse: tx_data consumed (TR written)
//  rx_valid   out  1  rx_data holds an unconsumed received byte
//  rx_data    out  8  received byte
//  rx_ready   in   1  consumer accepts rx_data when rx_valid&rx_ready
//  init_done  out  1  init sequence complete, UART usable
//  line_err   out  1  sticky: LS[7] (EI) seen on any LS read
//  bus_err    out  1  sticky: an access timed out
//  err_clr    in   1  synchronous clear of line_err and bus_err
// BEHAVIOUR
//  Reset values: all outputs 0, rx_data=8'h00, state=INIT_LC1, rr pointer=TX.
//  Bus: reg_req rises with addr/we/wdata stable and holds until reg_ack is sampled high.
//   reg_req is 0 in the cycle after ack, so there is >=1 idle cycle between accesses.
//   reg_ack while reg_req=0 is ignored.
//  Init writes, in order: LC=8'h83, DL1=CLK_DIV, DL2=8'h00, LC=8'h03, FC={FIFO_TRIG,6'b000110},
//   IE=8'h00. init_done rises in the cycle after the IE ack and stays 1 until reset.
//  Run FSM: IDLE -> LS_RD -> {TX_WR | RB_RD | GAP} -> IDLE.
//   IDLE: start LS_RD when tx_valid=1 or rx_valid=0; otherwise stay in IDLE (RX backpressure).
//   LS_RD: capture LS. line_err|=LS[7]. Candidates: TX if tx_valid&LS[5]; RX if LS[0]&!rx_valid.
//    Both candidates: serve the rr side, then toggle rr. One candidate: serve it, set rr to the
//    other side. None: GAP.
//   TX_WR: write TR=tx_data sampled at TX_WR entry. tx_ready pulses in the ack cycle.
//    tx_data must stay stable while tx_valid=1 and no tx_ready has been seen.
//   RB_RD: read RB. In the ack cycle load rx_data<=reg_rdata and set rx_valid. rx_valid clears
//    on the rx_valid&rx_ready handshake. No RB read is issued while rx_valid=1, so no byte is lost.
//   GAP: count POLL_GAP cycles, then IDLE. After TX_WR or RB_RD, return to IDLE with no gap.
//  Timeout: counter resets at each request start. At ACK_TIMEOUT cycles with no ack: drop
//   reg_req, set bus_err. During init, restart at INIT_LC1. During run, go to GAP. TX data is
//   not consumed on timeout (no tx_ready).
//  err_clr and a new error in the same cycle: the set wins.
//  rst_n low mid-transaction drops reg_req immediately (async). Init re-runs after release.
// TESTING
//  Reset release, ack=1 cycle after each req -> exactly 6 writes (3,83)(0,03)(1,00)(3,03)(2,06)(1,00);
//   init_done=1 in the cycle after the 6th ack.
//  tx_valid=1, data=8'h5A, LS returns 8'h60 -> LS read, then write (0,5A); one tx_ready pulse.
//  LS=8'h01, rx_ready=0 -> RB read 8'hC3 to rx_data; no further LS/RB access until rx_ready=1.
//  tx_valid=1 and LS=8'h61 on three successive polls -> service order TX,RX,TX (round-robin).
//  No ack during init for 64 cycles -> bus_err=1, reg_req drops, LC=8'h83 write reissued.
//  LS=8'hE0 -> line_err=1; err_clr pulse -> 0. Mid-TX_WR rst_n=0 -> all outputs 0 at once.

Source files
------------

// File: rtl/uart_host_seq.sv
// uart_host_seq: bus master for a 16550-style UART register port.
//
// After reset it programs the UART (LC=0x83, DL1=CLK_DIV, DL2=0x00, LC=0x03,
// FC={FIFO_TRIG,6'b000110}, IE=0x00). It then polls LS and uses the result
// to pace TR writes from the TX byte stream and RB reads into the RX holding
// register, arbitrating round-robin when both sides could move.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   reg_req/we/addr/wdata  register access request (held until reg_ack)
//   reg_rdata, reg_ack  read data and one-cycle acknowledge from the UART
//   tx_valid/tx_data    byte to transmit; tx_ready pulses when TR is written
//   rx_valid/rx_data    received byte holding register; rx_ready consumes it
//   init_done           init sequence complete
//   line_err, bus_err   sticky error flags, cleared by err_clr
//
// Handshakes: a bus access starts when reg_req rises with addr/we/wdata
// stable and completes in the cycle reg_ack is sampled high with reg_req=1;
// reg_req is 0 in the following cycle. tx_data is taken when tx_ready=1;
// rx_data is taken when rx_valid & rx_ready.
module uart_host_seq #(
  parameter logic [7:0] CLK_DIV     = 8'd3,
  parameter logic [1:0] FIFO_TRIG   = 2'b00,
  parameter int         POLL_GAP    = 8,
  parameter int         ACK_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       reg_req,
  output logic       reg_we,
  output logic [2:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  input  logic       reg_ack,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       init_done,
  output logic       line_err,
  output logic       bus_err,
  input  logic       err_clr
);

  typedef enum logic [3:0] {
    INIT_LC1, INIT_DL1, INIT_DL2, INIT_LC2, INIT_FC, INIT_IE,
    IDLE, LS_RD, TX_WR, RB_RD, GAP
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);
  localparam logic       RR_TX    = 1'b0;
  localparam logic       RR_RX    = 1'b1;

  state_t     state_q, state_d;
  logic       req_q, req_d;
  logic [7:0] cnt_q, cnt_d;     // ack timeout in access states, gap length in GAP
  logic       rr_q, rr_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       rx_valid_d;
  logic [7:0] rx_data_d;
  logic       init_done_d;
  logic       line_err_set, bus_err_set;

  logic       we_c;
  logic [2:0] addr_c;
  logic [7:0] wdata_c;
  logic       tx_cand, rx_cand;

  // Candidates are only meaningful in the LS_RD ack cycle, when reg_rdata is LS.
  assign tx_cand = tx_valid & reg_rdata[5];
  assign rx_cand = reg_rdata[0] & ~rx_valid;

  // Access attributes per state; gated by req_q so the port is all-zero when idle.
  always_comb begin
    we_c    = 1'b1;
    addr_c  = 3'd0;
    wdata_c = 8'h00;
    case (state_q)
      INIT_LC1: begin addr_c = 3'd3; wdata_c = 8'h83; end
      INIT_DL1: begin addr_c = 3'd0; wdata_c = CLK_DIV; end
      INIT_DL2: begin addr_c = 3'd1; wdata_c = 8'h00; end
      INIT_LC2: begin addr_c = 3'd3; wdata_c = 8'h03; end
      INIT_FC:  begin addr_c = 3'd2; wdata_c = {FIFO_TRIG, 6'b000110}; end
      INIT_IE:  begin addr_c = 3'd1; wdata_c = 8'h00; end
      LS_RD:    begin addr_c = 3'd5; we_c = 1'b0; end
      TX_WR:    begin addr_c = 3'd0; wdata_c = tx_byte_q; end
      RB_RD:    begin addr_c = 3'd0; we_c = 1'b0; end
      default:  we_c = 1'b0;
    endcase
  end

  assign reg_req   = req_q;
  assign reg_we    = req_q & we_c;
  assign reg_addr  = req_q ? addr_c : 3'd0;
  assign reg_wdata = (req_q & we_c) ? wdata_c : 8'h00;

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    cnt_d        = cnt_q;
    rr_d         = rr_q;
    tx_byte_d    = tx_byte_q;
    rx_valid_d   = rx_valid;
    rx_data_d    = rx_data;
    init_done_d  = init_done;
    line_err_set = 1'b0;
    bus_err_set  = 1'b0;
    tx_ready     = 1'b0;

    if (rx_valid && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        // With no TX work and a full RX register there is nothing a poll could do.
        if (tx_valid || !rx_valid) state_d = LS_RD;
      end
      GAP: begin
        if (cnt_q == GAP_LAST) state_d = IDLE;
        else                   cnt_d = cnt_q + 8'd1;
      end
      default: begin
        if (!req_q) begin
          req_d = 1'b1;
          cnt_d = 8'd0;
        end else if (reg_ack) begin
          req_d = 1'b0;
          case (state_q)
            INIT_LC1: state_d = INIT_DL1;
            INIT_DL1: state_d = INIT_DL2;
            INIT_DL2: state_d = INIT_LC2;
            INIT_LC2: state_d = INIT_FC;
            INIT_FC:  state_d = INIT_IE;
            INIT_IE: begin
              state_d     = IDLE;
              init_done_d = 1'b1;
            end
            LS_RD: begin
              line_err_set = reg_rdata[7];
              if (tx_cand && (!rx_cand || rr_q == RR_TX)) begin
                state_d   = TX_WR;
                tx_byte_d = tx_data;
                rr_d      = RR_RX;
              end else if (rx_cand) begin
                state_d = RB_RD;
                rr_d    = RR_TX;
              end else begin
                state_d = GAP;
                cnt_d   = 8'd0;
              end
            end
            TX_WR: begin
              tx_ready = 1'b1;
              state_d  = IDLE;
            end
            RB_RD: begin
              rx_data_d  = reg_rdata;
              rx_valid_d = 1'b1;
              state_d    = IDLE;
            end
            default: state_d = IDLE;
          endcase
        end else if (cnt_q == TMO_LAST) begin
          req_d       = 1'b0;
          bus_err_set = 1'b1;
          cnt_d       = 8'd0;
          state_d     = init_done ? GAP : INIT_LC1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT_LC1;
      req_q     <= 1'b0;
      cnt_q     <= 8'd0;
      rr_q      <= RR_TX;
      tx_byte_q <= 8'h00;
      rx_valid  <= 1'b0;
      rx_data   <= 8'h00;
      init_done <= 1'b0;
      line_err  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      tx_byte_q <= tx_byte_d;
      rx_valid  <= rx_valid_d;
      rx_data   <= rx_data_d;
      init_done <= init_done_d;
      // A new error in the same cycle as err_clr stays set.
      line_err  <= line_err_set | (line_err & ~err_clr);
      bus_err   <= bus_err_set | (bus_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_uart_host_seq.sv
// tb_uart_host_seq: directed bench for uart_host_seq acting as the UART
// register slave, with hand-computed expected access sequences.
module tb_uart_host_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       reg_req, reg_we;
  logic [2:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;
  logic       reg_ack;
  logic       tx_valid, tx_ready;
  logic [7:0] tx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] rx_data;
  logic       init_done, line_err, bus_err, err_clr;

  int   n_checks = 0;
  int   n_pass   = 0;
  logic ack_tx_ready;   // tx_ready captured inside the most recent ack cycle

  uart_host_seq dut (
    .clk(clk), .rst_n(rst_n),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .init_done(init_done), .line_err(line_err), .bus_err(bus_err),
    .err_clr(err_clr)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard check
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  // driver: wait (bounded) for reg_req, sampled on negedge
  task automatic wait_req(input string tag, output logic seen);
    int waited = 0;
    seen = 1'b0;
    while (waited < 200 && !seen) begin
      @(negedge clk);
      if (reg_req) seen = 1'b1;
      else waited++;
    end
    check({tag, "_req"}, 8'(seen), 8'd1);
  endtask

  // driver: expect one access, acknowledge it one cycle after req with rdata
  task automatic serve(input string tag, input logic we, input logic [2:0] addr,
                       input logic [7:0] wdata, input logic [7:0] rdata);
    logic seen;
    wait_req(tag, seen);
    if (seen) begin
      check({tag, "_addr"}, 8'(reg_addr), 8'(addr));
      check({tag, "_we"}, 8'(reg_we), 8'(we));
      if (we) check({tag, "_wdata"}, reg_wdata, wdata);
      reg_rdata = rdata;
      reg_ack   = 1'b1;
      #1 ack_tx_ready = tx_ready;
      @(negedge clk);
      reg_ack   = 1'b0;
      reg_rdata = 8'h00;
      check({tag, "_req_gap"}, 8'(reg_req), 8'd0);
    end
  endtask

  task automatic run_init(input string tag);
    serve({tag, "_lc1"}, 1'b1, 3'd3, 8'h83, 8'h00);
    serve({tag, "_dl1"}, 1'b1, 3'd0, 8'h03, 8'h00);
    serve({tag, "_dl2"}, 1'b1, 3'd1, 8'h00, 8'h00);
    serve({tag, "_lc2"}, 1'b1, 3'd3, 8'h03, 8'h00);
    serve({tag, "_fc"},  1'b1, 3'd2, 8'h06, 8'h00);
    check({tag, "_not_done"}, 8'(init_done), 8'd0);
    serve({tag, "_ie"},  1'b1, 3'd1, 8'h00, 8'h00);
    check({tag, "_done"}, 8'(init_done), 8'd1);
  endtask

  initial begin
    logic seen;
    int   cnt;
    rst_n = 1'b0; reg_rdata = 8'h00; reg_ack = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0; err_clr = 1'b0;
    ack_tx_ready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_req", 8'(reg_req), 8'd0);
    check("rst_addr", 8'(reg_addr), 8'd0);
    check("rst_wdata", reg_wdata, 8'h00);
    check("rst_rx_valid", 8'(rx_valid), 8'd0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_init_done", 8'(init_done), 8'd0);
    check("rst_errs", {6'd0, line_err, bus_err}, 8'd0);
    rst_n = 1'b1;

    // init sequence
    run_init("init");

    // single TX: LS=60 -> TR write 5A, one tx_ready
    tx_valid = 1'b1; tx_data = 8'h5A;
    serve("tx_ls", 1'b0, 3'd5, 8'h00, 8'h60);
    check("tx_ls_no_ready", 8'(ack_tx_ready), 8'd0);
    serve("tx_wr", 1'b1, 3'd0, 8'h5A, 8'h00);
    check("tx_ready_pulse", 8'(ack_tx_ready), 8'd1);
    check("tx_ready_low", 8'(tx_ready), 8'd0);
    tx_valid = 1'b0;

    // single RX with backpressure
    serve("rx_ls", 1'b0, 3'd5, 8'h00, 8'h01);
    serve("rx_rb", 1'b0, 3'd0, 8'h00, 8'hC3);
    check("rx_valid_set", 8'(rx_valid), 8'd1);
    check("rx_data", rx_data, 8'hC3);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (reg_req) cnt++;
    end
    check("rx_backpressure_idle", 8'(cnt), 8'd0);
    check("rx_still_valid", 8'(rx_valid), 8'd1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("rx_consumed", 8'(rx_valid), 8'd0);

    // round-robin TX, RX, TX with LS=61 on every poll
    tx_valid = 1'b1; tx_data = 8'h11; rx_ready = 1'b1;
    serve("rr1_ls", 1'b0, 3'd5, 8'h00, 8'h61);
    serve("rr1_tx", 1'b1, 3'd0, 8'h11, 8'h00);
    check("rr1_tx_ready", 8'(ack_tx_ready), 8'd1);
    tx_data = 8'h22;
    serve("rr2_ls", 1'b0, 3'd5, 8'h00, 8'h61);
    serve("rr2_rb", 1'b0, 3'd0, 8'h00, 8'h44);
    check("rr2_rx_valid", 8'(rx_valid), 8'd1);
    check("rr2_rx_data", rx_data, 8'h44);
    serve("rr3_ls", 1'b0, 3'd5, 8'h00, 8'h61);
    serve("rr3_tx", 1'b1, 3'd0, 8'h22, 8'h00);
    check("rr3_tx_ready", 8'(ack_tx_ready), 8'd1);
    tx_valid = 1'b0;

    // line error then clear
    serve("le_ls", 1'b0, 3'd5, 8'h00, 8'hE0);
    check("line_err_set", 8'(line_err), 8'd1);
    check("le_bus_err", 8'(bus_err), 8'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("line_err_clr", 8'(line_err), 8'd0);

    // init timeout: no ack for ACK_TIMEOUT cycles
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_req("tmo", seen);
    cnt = 0;
    while (reg_req && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check("tmo_req_cycles", 8'(cnt), 8'd64);
    check("tmo_req_drop", 8'(reg_req), 8'd0);
    check("tmo_bus_err", 8'(bus_err), 8'd1);
    check("tmo_not_done", 8'(init_done), 8'd0);
    run_init("reinit");
    check("reinit_bus_err_sticky", 8'(bus_err), 8'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("bus_err_clr", 8'(bus_err), 8'd0);

    // reset in the middle of a TR write
    tx_valid = 1'b1; tx_data = 8'h77;
    serve("mid_ls", 1'b0, 3'd5, 8'h00, 8'h60);
    wait_req("mid_tx", seen);
    check("mid_tx_addr", 8'(reg_addr), 8'd0);
    check("mid_tx_wdata", reg_wdata, 8'h77);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", 8'(reg_req), 8'd0);
    check("mid_rst_we", 8'(reg_we), 8'd0);
    check("mid_rst_wdata", reg_wdata, 8'h00);
    check("mid_rst_tx_ready", 8'(tx_ready), 8'd0);
    check("mid_rst_init_done", 8'(init_done), 8'd0);
    check("mid_rst_rx", {7'd0, rx_valid}, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
